// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding and instruction constants shared by the TAP responder.
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;
  localparam int IR_IDCODE = 1;
  localparam int IR_USER = 4;
  localparam logic [1:0] IR_CAPTURE = 2'b01;
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: two-flop synchroniser plus history flop giving level and single-cycle edge events.
module jtag_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic hist_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], d_i};
      hist_q <= sync_q[1];
    end
  end
  assign level_o = sync_q[1];
  assign rise_o = sync_q[1] & ~hist_q;
  assign fall_o = ~sync_q[1] & hist_q;
endmodule

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: oversampled IEEE 1149.1 TAP with IR, IDCODE, BYPASS and one USER data register.
module jtag_tap_sampled
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h249511C3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                trst_ni,
  output logic                tdo_o,
  output logic                tdo_en_o,
  output logic [3:0]          tap_state_o,
  input  logic [DR_WIDTH-1:0] user_data_i,
  output logic [DR_WIDTH-1:0] user_data_o,
  output logic                user_capture_o,
  output logic                user_update_o
);
  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s;
  logic [6:0] unused_sync;
  jtag_sync_edge u_tck (.clk_i(clk_i), .rst_i(rst_i), .d_i(tck_i), .level_o(unused_sync[0]), .rise_o(tck_rise), .fall_o(tck_fall));
  jtag_sync_edge u_tms (.clk_i(clk_i), .rst_i(rst_i), .d_i(tms_i), .level_o(tms_s), .rise_o(unused_sync[1]), .fall_o(unused_sync[2]));
  jtag_sync_edge u_tdi (.clk_i(clk_i), .rst_i(rst_i), .d_i(tdi_i), .level_o(tdi_s), .rise_o(unused_sync[3]), .fall_o(unused_sync[4]));
  jtag_sync_edge #(.RST_VAL(1'b1)) u_trst (.clk_i(clk_i), .rst_i(rst_i), .d_i(trst_ni), .level_o(trst_s), .rise_o(unused_sync[5]), .fall_o(unused_sync[6]));
  tap_state_e state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0] id_sr_q;
  logic [DR_WIDTH-1:0] usr_sr_q, user_data_q;
  logic byp_q, tdo_q, tdo_en_q, cap_q, upd_q;
  logic sel_id, sel_usr, is_shift, shift_lsb;
  assign sel_id = ir_q == IR_WIDTH'(IR_IDCODE);
  assign sel_usr = ir_q == IR_WIDTH'(IR_USER);
  assign is_shift = state_q == SHIFT_IR || state_q == SHIFT_DR;
  assign shift_lsb = state_q == SHIFT_IR ? ir_sr_q[0] : sel_id ? id_sr_q[0] : sel_usr ? usr_sr_q[0] : byp_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms_s ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         state_d = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         state_d = tms_s ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_d = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         state_d = tms_s ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         state_d = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         state_d = tms_s ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_d = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         state_d = tms_s ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TEST_LOGIC_RESET;
      ir_q <= IR_WIDTH'(IR_IDCODE);
      ir_sr_q <= '0;
      id_sr_q <= '0;
      usr_sr_q <= '0;
      byp_q <= 1'b0;
      user_data_q <= '0;
      tdo_q <= 1'b0;
      tdo_en_q <= 1'b0;
      cap_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      cap_q <= trst_s && tck_rise && state_q == CAPTURE_DR && sel_usr;
      upd_q <= trst_s && tck_rise && state_q == UPDATE_DR && sel_usr;
      if (!trst_s) begin
        state_q <= TEST_LOGIC_RESET;
        ir_q <= IR_WIDTH'(IR_IDCODE);
      end else begin
        if (tck_rise) begin
          state_q <= state_d;
          case (state_q)
            CAPTURE_IR: ir_sr_q <= IR_WIDTH'(IR_CAPTURE);
            SHIFT_IR:   ir_sr_q <= IR_WIDTH'({tdi_s, ir_sr_q} >> 1);
            UPDATE_IR:  ir_q <= ir_sr_q;
            CAPTURE_DR: begin
              id_sr_q <= IDCODE_VAL;
              byp_q <= 1'b0;
              if (sel_usr) usr_sr_q <= user_data_i;
            end
            SHIFT_DR: begin
              if (sel_id) id_sr_q <= {tdi_s, id_sr_q[31:1]};
              else if (sel_usr) usr_sr_q <= DR_WIDTH'({tdi_s, usr_sr_q} >> 1);
              else byp_q <= tdi_s;
            end
            UPDATE_DR:  if (sel_usr) user_data_q <= usr_sr_q;
            default: ;
          endcase
        end
        // Holding TLR keeps IDCODE selected regardless of what Update-IR did
        if (state_q == TEST_LOGIC_RESET) ir_q <= IR_WIDTH'(IR_IDCODE);
      end
      if (tck_fall) begin
        tdo_q <= is_shift & shift_lsb;
        tdo_en_q <= is_shift;
      end
    end
  end
  assign tdo_o = tdo_q;
  assign tdo_en_o = tdo_en_q;
  assign tap_state_o = state_q;
  assign user_data_o = user_data_q;
  assign user_capture_o = cap_q;
  assign user_update_o = upd_q;
endmodule
